alu_result_serializer: RTL
==========================

// Module: alu_result_serializer
// PURPOSE
//  Output side of the CR16 byte-wide ALU bench interface. Captures one ALU result word plus the
//  5-bit status flags and emits them over an 8-bit valid/ready byte stream: MSB byte first, then
//  an optional status byte. Sits between the alu output (O_C, O_STATUS) and a byte sink such as a
//  UART TX or a host FIFO. One frame is in flight at a time.
// PARAMETERS
//  P_WIDTH        16  result width in bits; must be a multiple of 8, minimum 8
//  P_SEND_STATUS  1   1: append status byte {3'b000, status[4:0]}; 0: result bytes only
// PORTS
//  I_CLK          in   1        single clock; all state updates on the rising edge
//  I_NRESET       in   1        asynchronous, active-low reset
//  I_RESULT       in   P_WIDTH  ALU result word, sampled on the capture edge
//  I_STATUS       in   5        ALU status flags, sampled on the capture edge
//  I_VALID        in   1        result/status valid
//  O_READY        out  1        serializer idle and able to capture; registered
//  O_BYTE         out  8        current output byte; registered
//  O_BYTE_VALID   out  1        O_BYTE holds a valid byte
//  I_BYTE_READY   in   1        sink accepts O_BYTE this cycle
//  O_LAST         out  1        high with O_BYTE_VALID on the final byte of the frame
// BEHAVIOUR
//  Reset (async, any state): state=S_IDLE, O_READY=1, O_BYTE=8'h00, O_BYTE_VALID=0, O_LAST=0,
//   internal word/status/byte counter cleared. A frame in progress is abandoned, nothing resumes.
//  N = P_WIDTH/8 + P_SEND_STATUS bytes per frame; byte index counter is clog2(N) bits wide.
//  States: S_IDLE -> S_SEND -> S_IDLE.
//   S_IDLE: O_READY=1. Capture when I_VALID && O_READY at a rising edge: latch I_RESULT and
//    I_STATUS, load O_BYTE=I_RESULT[P_WIDTH-1 -: 8], O_BYTE_VALID=1, index=0, go to S_SEND.
//    Without I_VALID, stay in S_IDLE.
//   S_SEND: O_READY=0. I_VALID and input changes are ignored; latched copies are used.
//    Transfer = O_BYTE_VALID && I_BYTE_READY at an edge. On transfer of a byte that is not the
//     last: index+1, O_BYTE = next latched result byte (descending significance), then the
//     status byte.
//    On transfer of the last byte: O_BYTE_VALID=0, O_LAST=0, go to S_IDLE (O_READY=1 next cycle).
//    No transfer: O_BYTE, O_LAST and O_BYTE_VALID hold (stall; the sink may hold off indefinitely).
//  O_LAST = 1 exactly while the byte at index N-1 is presented.
//  Latency: first byte valid in the cycle after the capture edge. Minimum frame period N+1
//   cycles (one idle cycle between frames; no same-cycle re-capture on the last transfer).
//  Once asserted, O_BYTE_VALID never drops before its transfer completes.
//  P_WIDTH=8, P_SEND_STATUS=0 (N=1): that single byte has O_LAST=1.
// STRUCTURE
//  Shared header cr16_defines.vh: CR16 byte width (8) and ALU status width (5), also used by
//   alu and alu_top. State localparams and the byte counter stay local to this module.
//  Byte selection is an indexed part-select on the latched word; no sub-module is needed.
// TESTING
//  1 Reset: I_NRESET=0 -> O_READY=1, O_BYTE_VALID=0, O_BYTE=00, O_LAST=0, also asserted mid-clock.
//  2 Basic frame: I_RESULT=16'hBEEF, I_STATUS=5'b10101, I_BYTE_READY=1 -> bytes BE, EF, 15 on
//    consecutive cycles, O_LAST only on 15, O_READY high again the cycle after 15 transfers.
//  3 Backpressure: same frame with I_BYTE_READY=0 for 3 cycles on EF -> EF stays stable, valid held,
//    no duplicates or drops. Sequence stays BE, EF, 15.
//  4 Busy-ignore: during frame 16'h1234, drive I_VALID=1 with 16'hFFFF -> output 12, 34, status
//    only. 16'hFFFF is captured after return to idle only if I_VALID is still high.
//  5 Reset mid-frame: assert I_NRESET=0 after byte 12 transfers -> outputs go to reset values at
//    once. A new frame 16'hA5C3 after release emits A5, C3, status.
//  6 Params: P_SEND_STATUS=0, P_WIDTH=32, 32'h01020304 -> 01,02,03,04, O_LAST on 04. N+1 cycle period.

Source files
------------

// File: rtl/alu_result_serializer_pkg.sv
// Shared CR16 byte-stream constants, serializer state type and small helpers.
package alu_result_serializer_pkg;

   // CR16 byte width and ALU status flag width (shared with the ALU side).
   localparam int CR16_BYTE_W   = 8;
   localparam int CR16_STATUS_W = 5;

   // Serializer control states: waiting for a result, or streaming a frame.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } ser_state_e;

   // Byte-index counter width; a one-byte frame still gets a 1-bit counter.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Status byte as sent on the wire: zero-padded flags in the low bits.
   function automatic logic [CR16_BYTE_W-1:0] status_byte(input logic [CR16_STATUS_W-1:0] s);
      return {{(CR16_BYTE_W - CR16_STATUS_W){1'b0}}, s};
   endfunction

endpackage

// File: rtl/alu_result_serializer.sv
// Captures one ALU result plus status flags and streams them out as a
// valid/ready byte frame: result bytes MSB first, then an optional status byte.
module alu_result_serializer
   import alu_result_serializer_pkg::*;
#(
   parameter int P_WIDTH       = 16,
   parameter int P_SEND_STATUS = 1
) (
   input  logic                     I_CLK,
   input  logic                     I_NRESET,
   input  logic [P_WIDTH-1:0]       I_RESULT,
   input  logic [CR16_STATUS_W-1:0] I_STATUS,
   input  logic                     I_VALID,
   output logic                     O_READY,
   output logic [CR16_BYTE_W-1:0]   O_BYTE,
   output logic                     O_BYTE_VALID,
   input  logic                     I_BYTE_READY,
   output logic                     O_LAST
);

   localparam int NRES  = P_WIDTH / CR16_BYTE_W;
   localparam int N     = NRES + P_SEND_STATUS;
   localparam int IDX_W = idx_width(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic SINGLE_BYTE = (N == 1);

   ser_state_e               state_q, state_d;
   logic [P_WIDTH-1:0]       word_q, word_d;
   logic [CR16_STATUS_W-1:0] status_q, status_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [CR16_BYTE_W-1:0]   byte_q, byte_d;
   logic                     byte_valid_q, byte_valid_d;
   logic                     last_q, last_d;
   logic                     ready_q, ready_d;

   logic [IDX_W-1:0]         nxt_idx;
   logic [CR16_BYTE_W-1:0]   sel_byte;
   logic [CR16_BYTE_W-1:0]   res_bytes [NRES];

   // Slice the latched word into bytes, index 0 being the most significant.
   for (genvar gi = 0; gi < NRES; gi++) begin : g_res_bytes
      assign res_bytes[gi] = word_q[P_WIDTH-1-CR16_BYTE_W*gi -: CR16_BYTE_W];
   end

   // Pick the byte that follows the current one; past the result bytes it is the status byte.
   always_comb begin
      nxt_idx  = idx_q + 1'b1;
      sel_byte = status_byte(status_q);
      for (int b = 0; b < NRES; b++) begin
         if (nxt_idx == IDX_W'(b)) begin
            sel_byte = res_bytes[b];
         end
      end
   end

   // Next-state and output logic: capture in idle, advance on each accepted byte.
   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      status_d     = status_q;
      idx_d        = idx_q;
      byte_d       = byte_q;
      byte_valid_d = byte_valid_q;
      last_d       = last_q;
      ready_d      = ready_q;
      case (state_q)
         S_IDLE: begin
            if (I_VALID && ready_q) begin
               word_d       = I_RESULT;
               status_d     = I_STATUS;
               byte_d       = I_RESULT[P_WIDTH-1 -: CR16_BYTE_W];
               byte_valid_d = 1'b1;
               idx_d        = '0;
               last_d       = SINGLE_BYTE;
               ready_d      = 1'b0;
               state_d      = S_SEND;
            end
         end
         S_SEND: begin
            if (byte_valid_q && I_BYTE_READY) begin
               if (last_q) begin
                  // Frame done; re-capture only becomes possible on the following edge.
                  byte_valid_d = 1'b0;
                  last_d       = 1'b0;
                  idx_d        = '0;
                  ready_d      = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  idx_d  = nxt_idx;
                  byte_d = sel_byte;
                  last_d = (nxt_idx == LAST_IDX);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset; a reset abandons any frame.
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state_q      <= S_IDLE;
         word_q       <= '0;
         status_q     <= '0;
         idx_q        <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         last_q       <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         status_q     <= status_d;
         idx_q        <= idx_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         last_q       <= last_d;
         ready_q      <= ready_d;
      end
   end

   assign O_READY      = ready_q;
   assign O_BYTE       = byte_q;
   assign O_BYTE_VALID = byte_valid_q;
   assign O_LAST       = last_q;

endmodule
